// File: rtl/comb_multiplier_if.sv
// ============================================================================
// comb_multiplier_if : operand/product bundle for the array multiplier. Rev 1.0
// ============================================================================
`default_nettype none

interface comb_multiplier_if #(
  parameter int N = 8
);
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] Q;

  modport master (output A, output B, input Q);
  modport slave  (input A, input B, output Q);
endinterface

`default_nettype wire

// File: rtl/comb_multiplier.sv
// ============================================================================
// comb_multiplier : unsigned N x N -> 2N AND/full-adder array, registered Q. Rev 1.0
// ============================================================================
`default_nettype none

module comb_multiplier #(
  parameter int N = 8
) (
  input  wire               clock,
  input  wire               nreset,
  comb_multiplier_if.slave  bus
);

  wire [2*N-1:0] prod;
  logic [2*N-1:0] q_reg;

  // Each row holds an (N+1)-bit running sum; its LSB is a finished product bit
  // and the upper N bits are added to the next partial-product row.
  for (genvar i = 0; i < N; i++) begin : g_row
    wire [N-1:0] pp;
    wire [N:0]   acc;

    assign pp = bus.A & {N{bus.B[i]}};

    if (i == 0) begin : g_first
      assign acc = {1'b0, pp};
    end else begin : g_add
      for (genvar j = 0; j < N; j++) begin : g_fa
        wire x;
        wire y;
        wire ci;
        wire s;
        wire co;

        assign x = pp[j];
        assign y = g_row[i-1].acc[j+1];

        if (j == 0) begin : g_cin0
          assign ci = 1'b0;
        end else begin : g_cinj
          assign ci = g_fa[j-1].co;
        end

        assign s      = x ^ y ^ ci;
        assign co     = (x & y) | (ci & (x ^ y));
        assign acc[j] = s;

        if (j == N - 1) begin : g_cout
          assign acc[N] = co;
        end
      end
    end

    assign prod[i] = acc[0];
  end

  assign prod[2*N-1:N] = g_row[N-1].acc[N:1];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      q_reg <= '0;
    end else begin
      q_reg <= prod;
    end
  end

  assign bus.Q = q_reg;

endmodule

`default_nettype wire

// File: tb/tb_comb_multiplier.sv
// ============================================================================
// tb_comb_multiplier : table-driven and scoreboard checks for comb_multiplier. Rev 1.0
// ============================================================================
`default_nettype none

module tb_comb_multiplier;

  logic clock;
  logic nreset;

  comb_multiplier_if #(.N(8))  bus8 ();
  comb_multiplier_if #(.N(4))  bus4 ();
  comb_multiplier_if #(.N(16)) bus16 ();

  comb_multiplier #(.N(8))  dut8  (.clock(clock), .nreset(nreset), .bus(bus8));
  comb_multiplier #(.N(4))  dut4  (.clock(clock), .nreset(nreset), .bus(bus4));
  comb_multiplier #(.N(16)) dut16 (.clock(clock), .nreset(nreset), .bus(bus16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] q;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] sb8  [$];
  logic [7:0]  sb4  [$];
  logic [31:0] sb16 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop8(input string name);
    logic [15:0] e;
    if (sb8.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, bus8.Q);
    end else begin
      e = sb8.pop_front();
      check(name, {16'h0, bus8.Q}, {16'h0, e});
    end
  endtask

  task automatic pop_wide(input int k);
    logic [7:0]  e4;
    logic [31:0] e16;
    if (sb4.size() == 0 || sb16.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rand_wide[%0d]: scoreboard empty, got 0x%0h 0x%0h", k, bus4.Q, bus16.Q);
    end else begin
      e4  = sb4.pop_front();
      e16 = sb16.pop_front();
      check($sformatf("rand_n4[%0d]", k),  {24'h0, bus4.Q}, {24'h0, e4});
      check($sformatf("rand_n16[%0d]", k), bus16.Q, e16);
    end
  endtask

  // Drive at the falling edge, push the expected product, compare just after the rising edge.
  task automatic step8(input logic [7:0] a, input logic [7:0] b, input string name);
    @(negedge clock);
    bus8.A = a;
    bus8.B = b;
    sb8.push_back(16'(a) * 16'(b));
    @(posedge clock);
    #1;
    pop8(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got n_cmp=%0d, expected completion", n_cmp);
    $fatal(1);
  end

  vec_t vecs [9];

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [3:0]  r4a;
    logic [3:0]  r4b;
    logic [15:0] r16a;
    logic [15:0] r16b;

    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
    vecs[2] = '{8'hFF,  8'h01,  16'h00FF};
    vecs[3] = '{8'h80,  8'h02,  16'h0100};
    vecs[4] = '{8'h00,  8'hA5,  16'h0000};
    vecs[5] = '{8'h01,  8'hA5,  16'h00A5};
    vecs[6] = '{8'd3,   8'd4,   16'h000C};
    vecs[7] = '{8'd100, 8'd200, 16'h4E20};
    vecs[8] = '{8'd255, 8'd2,   16'h01FE};

    nreset   = 1'b0;
    bus8.A   = 8'h12;
    bus8.B   = 8'h34;
    bus4.A   = '0;
    bus4.B   = '0;
    bus16.A  = '0;
    bus16.B  = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_hold", {16'h0, bus8.Q}, 32'h0);
    check("reset_hold_n4", {24'h0, bus4.Q}, 32'h0);
    check("reset_hold_n16", bus16.Q, 32'h0);

    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_release", {16'h0, bus8.Q}, 32'h03A8);

    // Operand change must not reach Q before the next edge.
    @(negedge clock);
    bus8.A = vecs[0].a;
    bus8.B = vecs[0].b;
    #1;
    check("before_edge", {16'h0, bus8.Q}, 32'h03A8);
    @(posedge clock);
    #1;
    check("after_edge", {16'h0, bus8.Q}, {16'h0, vecs[0].q});

    // Table vectors back-to-back, also cross-checked against the table's constants.
    for (int i = 1; i < 9; i++) begin
      @(negedge clock);
      bus8.A = vecs[i].a;
      bus8.B = vecs[i].b;
      sb8.push_back(vecs[i].q);
      @(posedge clock);
      #1;
      pop8($sformatf("table[%0d]", i));
    end

    // Asynchronous reset between edges while holding 0xFE01.
    step8(8'hFF, 8'hFF, "pre_async");
    #2;
    nreset = 1'b0;
    #1;
    check("async_reset", {16'h0, bus8.Q}, 32'h0);
    bus8.A = 8'd7;
    bus8.B = 8'd9;
    @(posedge clock);
    #1;
    check("reset_held_edge", {16'h0, bus8.Q}, 32'h0);
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    check("post_reset_load", {16'h0, bus8.Q}, 32'd63);

    // Random vectors on all three widths in lockstep.
    for (int k = 0; k < 1000; k++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      r4a  = 4'($urandom);
      r4b  = 4'($urandom);
      r16a = 16'($urandom);
      r16b = 16'($urandom);
      if (k < 256) begin
        r4a = 4'(k);
        r4b = 4'(k >> 4);
      end
      if (k == 1) begin
        r16a = 16'hFFFF;
        r16b = 16'hFFFF;
      end
      @(negedge clock);
      bus8.A  = ra;
      bus8.B  = rb;
      bus4.A  = r4a;
      bus4.B  = r4b;
      bus16.A = r16a;
      bus16.B = r16b;
      sb8.push_back(16'(ra) * 16'(rb));
      sb4.push_back(8'(r4a) * 8'(r4b));
      sb16.push_back(32'(r16a) * 32'(r16b));
      @(posedge clock);
      #1;
      pop8($sformatf("rand_n8[%0d]", k));
      pop_wide(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
